// File: rtl/btc_nonce_sched_pkg.sv
// Shared constants for the nonce scheduler: controller states, SHA-256 IV,
// padding words and the byte-swap used to place the nonce in the header.
package btc_nonce_sched_pkg;

  typedef enum logic [2:0] {
    IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, CHECK, FIN
  } state_t;

  localparam logic [255:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] PAD_WORD = 32'h80000000;
  localparam logic [31:0] LEN_P1   = 32'h00000280;
  localparam logic [31:0] LEN_P2   = 32'h00000100;

  // Header fields are little-endian while SHA words are big-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

endpackage

// File: rtl/btc_nonce_sched_msg_mux.sv
// Message word selector: returns the 32-bit SHA input word for a given pass
// (0 = header block 2, 1 = hash of hash1) and word address.
module btc_msg_mux
  import btc_nonce_sched_pkg::*;
(
  input  logic         pass,
  input  logic [3:0]   addr,
  input  logic [95:0]  tail,
  input  logic [31:0]  nonce,
  input  logic [255:0] hash1,
  output logic [31:0]  word
);

  always_comb begin
    word = '0;
    if (!pass) begin
      case (addr)
        4'd0:    word = tail[95:64];
        4'd1:    word = tail[63:32];
        4'd2:    word = tail[31:0];
        4'd3:    word = bswap32(nonce);
        4'd4:    word = PAD_WORD;
        4'd15:   word = LEN_P1;
        default: word = '0;
      endcase
    end else begin
      // H0 sits in the top word, so word n is at bit offset (7-n)*32.
      if (!addr[3])            word = hash1[{~addr[2:0], 5'd0} +: 32];
      else if (addr == 4'd8)   word = PAD_WORD;
      else if (addr == 4'd15)  word = LEN_P2;
    end
  end

endmodule

// File: rtl/btc_nonce_sched.sv
// Bitcoin nonce search controller: drives an external SHA-256 core through two
// passes per nonce and stops on a hit, at the end of the range, or on abort.
module btc_nonce_sched
  import btc_nonce_sched_pkg::*;
#(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [255:0]       midstate,
  input  logic [95:0]        tail,
  input  logic [31:0]        target,
  input  logic [NONCE_W-1:0] nonce_start,
  input  logic [NONCE_W-1:0] nonce_end,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [NONCE_W-1:0] found_nonce,
  output logic [255:0]       found_hash,
  output logic               core_start,
  output logic [255:0]       core_state_in,
  input  logic               core_rq,
  input  logic [3:0]         core_addr,
  output logic               core_rdy,
  output logic [31:0]        core_data,
  input  logic [255:0]       core_state_out,
  input  logic               core_done
);

  state_t             state;
  logic [255:0]       mid_r;
  logic [255:0]       hash1;
  logic [95:0]        tail_r;
  logic [31:0]        target_r;
  logic [NONCE_W-1:0] nonce;
  logic [NONCE_W-1:0] nonce_end_r;
  logic               abort_pend;
  logic               pass;
  logic [31:0]        word;

  btc_msg_mux u_msg_mux (
    .pass  (pass),
    .addr  (core_addr),
    .tail  (tail_r),
    .nonce (nonce),
    .hash1 (hash1),
    .word  (word)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      found         <= 1'b0;
      found_nonce   <= '0;
      found_hash    <= '0;
      core_start    <= 1'b0;
      core_state_in <= '0;
      core_rdy      <= 1'b0;
      core_data     <= '0;
      abort_pend    <= 1'b0;
      pass          <= 1'b0;
      nonce         <= '0;
      nonce_end_r   <= '0;
      target_r      <= '0;
      mid_r         <= '0;
      tail_r        <= '0;
      hash1         <= '0;
    end else begin
      core_start <= 1'b0;
      done       <= 1'b0;
      // Word bus is serviced in every state so an abort never strands the core mid-load.
      core_rdy <= core_rq && !core_rdy;
      if (core_rq && !core_rdy) core_data <= word;
      if (abort && busy) abort_pend <= 1'b1;

      case (state)
        IDLE: begin
          if (start) begin
            mid_r       <= midstate;
            tail_r      <= tail;
            target_r    <= target;
            nonce       <= nonce_start;
            nonce_end_r <= nonce_end;
            found       <= 1'b0;
            abort_pend  <= 1'b0;
            busy        <= 1'b1;
            state       <= P1_GO;
          end
        end
        P1_GO: begin
          if (abort_pend) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            core_start    <= 1'b1;
            core_state_in <= mid_r;
            pass          <= 1'b0;
            state         <= P1_WAIT;
          end
        end
        P1_WAIT: begin
          if (core_done) begin
            hash1 <= core_state_out;
            state <= P2_GO;
          end
        end
        P2_GO: begin
          if (abort_pend) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            core_start    <= 1'b1;
            core_state_in <= SHA256_IV;
            pass          <= 1'b1;
            state         <= P2_WAIT;
          end
        end
        P2_WAIT: begin
          if (core_done) begin
            found_hash <= core_state_out;
            state      <= CHECK;
          end
        end
        CHECK: begin
          if (found_hash[31:0] <= target_r) begin
            found       <= 1'b1;
            found_nonce <= nonce;
            done        <= 1'b1;
            busy        <= 1'b0;
            state       <= FIN;
          end else if (nonce == nonce_end_r || abort_pend) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= FIN;
          end else begin
            nonce <= nonce + 1'b1;
            state <= P1_GO;
          end
        end
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_btc_nonce_sched.sv
// Bench for btc_nonce_sched: behavioural SHA-256 core on the word bus plus a
// plain-loop double-SHA reference model of the nonce search.
module tb_btc_nonce_sched;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst, start, abort;
  logic [255:0] midstate;
  logic [95:0]  tail;
  logic [31:0]  target, nonce_start, nonce_end;
  logic         busy, done, found;
  logic [31:0]  found_nonce;
  logic [255:0] found_hash;
  logic         core_start, core_rq, core_rdy, core_done;
  logic [255:0] core_state_in, core_state_out;
  logic [3:0]   core_addr;
  logic [31:0]  core_data;

  btc_nonce_sched #(.NONCE_W(32)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .midstate(midstate), .tail(tail), .target(target),
    .nonce_start(nonce_start), .nonce_end(nonce_end),
    .busy(busy), .done(done), .found(found),
    .found_nonce(found_nonce), .found_hash(found_hash),
    .core_start(core_start), .core_state_in(core_state_in),
    .core_rq(core_rq), .core_addr(core_addr), .core_rdy(core_rdy),
    .core_data(core_data), .core_state_out(core_state_out), .core_done(core_done)
  );

  localparam logic [255:0] IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  // Genesis header: version, zero prev-hash, merkle root, time, bits.
  localparam logic [511:0] GEN_BLK1 = {32'h01000000, 256'h0,
    224'h3ba3edfd_7a7b12b2_7ac72c3e_67768f61_7fc81bc3_888a5132_3a9fb8aa};
  localparam logic [95:0]  GEN_TAIL = 96'h4b1e5e4a_29ab5f49_ffff001d;

  int vectors = 0, miscompares = 0, cyc = 0, proto_err = 0;
  int core_starts = 0, p2_starts = 0, words_served = 0, last_done_cyc = 0, done_cyc = 0;
  logic [31:0]  tried_q[$];
  logic [31:0]  exp_q[$];
  logic         m_found;
  logic [31:0]  m_nonce;
  logic [255:0] m_hash;
  logic [255:0] gen_mid;
  logic         prev_rdy = 1'b0, prev_done = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ((core_rdy && prev_rdy) || (done && prev_done))) proto_err <= proto_err + 1;
    prev_rdy  <= core_rdy;
    prev_done <= done;
  end

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bswap(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] sha_compress(input logic [255:0] st, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    for (int t = 0; t < 16; t++) w[t] = blk[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++)
      w[t] = (ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
           + (ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    {a, b, c, d, e, f, g, h} = st;
    for (int t = 0; t < 64; t++) begin
      t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {st[255:224] + a, st[223:192] + b, st[191:160] + c, st[159:128] + d,
            st[127:96] + e, st[95:64] + f, st[63:32] + g, st[31:0] + h};
  endfunction

  // Reference: walk the range, double-hash each nonce, stop on hit or range end.
  task automatic model_run(input logic [255:0] mid, input logic [95:0] tl,
                           input logic [31:0] tgt, input logic [31:0] ns, input logic [31:0] ne);
    logic [31:0]  n;
    logic [255:0] h1, h2;
    n = ns; m_found = 1'b0; m_nonce = '0; m_hash = '0;
    exp_q.delete();
    for (int k = 0; k < 64; k++) begin
      h1 = sha_compress(mid, {tl, bswap(n), 32'h80000000, 320'h0, 32'h00000280});
      h2 = sha_compress(IV, {h1, 32'h80000000, 192'h0, 32'h00000100});
      exp_q.push_back(n);
      m_hash = h2;
      if (h2[31:0] <= tgt) begin m_found = 1'b1; m_nonce = n; break; end
      if (n == ne) break;
      n = n + 32'd1;
    end
  endtask

  // Behavioural SHA core: fetch 16 words over the rq/rdy bus, then compress.
  task automatic run_core();
    logic [255:0] st;
    logic [511:0] blk;
    bit killed;
    st = core_state_in; blk = '0; killed = 1'b0;
    core_starts++;
    if (st === IV) p2_starts++;
    for (int i = 0; i < 16; i++) begin
      core_rq = 1'b1; core_addr = 4'(i);
      do begin @(posedge clk); #1; killed = rst; end while (!core_rdy && !killed);
      if (killed) break;
      blk[511 - 32*i -: 32] = core_data;
      words_served++;
    end
    core_rq = 1'b0;
    if (!killed) begin
      @(posedge clk); #1;
      if (!rst) begin
        core_state_out = sha_compress(st, blk);
        if (blk[31:0] == 32'h00000280) tried_q.push_back(bswap(blk[415:384]));
        core_done = 1'b1; last_done_cyc = cyc;
        @(posedge clk); #1;
        core_done = 1'b0;
      end
    end
  endtask

  initial begin : core_model
    core_rq = 1'b0; core_addr = '0; core_done = 1'b0; core_state_out = '0;
    forever begin
      @(posedge clk); #1;
      if (!rst && core_start) run_core();
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, time=%0t required < 2000000", $time);
    $fatal(1);
  end

  task automatic launch(input logic [255:0] mid, input logic [95:0] tl, input logic [31:0] tgt,
                        input logic [31:0] ns, input logic [31:0] ne);
    repeat (2) @(negedge clk);
    midstate = mid; tail = tl; target = tgt; nonce_start = ns; nonce_end = ne;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      @(posedge clk); #1;
      if (done) begin ok = 1'b1; done_cyc = cyc; break; end
    end
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL %s_timeout: done=0 required 1", name);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b0; abort = 1'b0; midstate = '0; tail = '0;
    target = '0; nonce_start = '0; nonce_end = '0;
    repeat (3) @(posedge clk); #1;
    vectors++;
    if ({busy, done, found, core_start, core_rdy} !== 5'b0) begin
      miscompares++; $display("FAIL reset_ctrl: got %b required 00000", {busy, done, found, core_start, core_rdy});
    end
    vectors++;
    if ({found_nonce, core_data} !== 64'h0) begin
      miscompares++; $display("FAIL reset_words: got %h %h required 0", found_nonce, core_data);
    end
    vectors++;
    if ({found_hash, core_state_in} !== 512'h0) begin
      miscompares++; $display("FAIL reset_state: got %h %h required 0", found_hash, core_state_in);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_genesis_hit;
    int base; bit ok;
    base = tried_q.size();
    model_run(gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1A, 32'h7C2BAC20);
    launch(gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1A, 32'h7C2BAC20);
    wait_done("genesis", ok);
    vectors++;
    if (found !== 1'b1 || busy !== 1'b0) begin
      miscompares++; $display("FAIL genesis_found: got found=%b busy=%b required 1 0", found, busy);
    end
    vectors++;
    if (found_nonce !== 32'h7C2BAC1D) begin
      miscompares++; $display("FAIL genesis_nonce: got %h required 7c2bac1d", found_nonce);
    end
    vectors++;
    if (tried_q.size() - base !== 4) begin
      miscompares++; $display("FAIL genesis_tries: got %0d required 4", tried_q.size() - base);
    end
    vectors++;
    if (found_hash[31:0] !== 32'h0) begin
      miscompares++; $display("FAIL genesis_h7: got %h required 00000000", found_hash[31:0]);
    end
    vectors++;
    if (found_hash !== m_hash) begin
      miscompares++; $display("FAIL genesis_hash: got %h required %h", found_hash, m_hash);
    end
  endtask

  // Shared shape for the range tests: compares tried order, found and hash.
  task automatic test_range(input string name, input logic [255:0] mid, input logic [95:0] tl,
                            input logic [31:0] tgt, input logic [31:0] ns, input logic [31:0] ne,
                            input int exp_tries);
    int base; bit ok;
    base = tried_q.size();
    model_run(mid, tl, tgt, ns, ne);
    launch(mid, tl, tgt, ns, ne);
    wait_done(name, ok);
    vectors++;
    if (exp_tries >= 0 && tried_q.size() - base !== exp_tries) begin
      miscompares++; $display("FAIL %s_tries: got %0d required %0d", name, tried_q.size() - base, exp_tries);
    end
    vectors++;
    if (tried_q.size() - base !== exp_q.size()) begin
      miscompares++; $display("FAIL %s_count: got %0d required %0d", name, tried_q.size() - base, exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      vectors++;
      if (base + i >= tried_q.size() || tried_q[base + i] !== exp_q[i]) begin
        miscompares++;
        $display("FAIL %s_order[%0d]: got %h required %h", name, i,
                 (base + i < tried_q.size()) ? tried_q[base + i] : 32'hx, exp_q[i]);
      end
    end
    vectors++;
    if (found !== m_found) begin
      miscompares++; $display("FAIL %s_found: got %b required %b", name, found, m_found);
    end
    if (m_found) begin
      vectors++;
      if (found_nonce !== m_nonce) begin
        miscompares++; $display("FAIL %s_nonce: got %h required %h", name, found_nonce, m_nonce);
      end
    end
    vectors++;
    if (found_hash !== m_hash) begin
      miscompares++; $display("FAIL %s_hash: got %h required %h", name, found_hash, m_hash);
    end
  endtask

  task automatic test_boundaries;
    test_range("genesis_miss", gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1E, 32'h7C2BAC20, 3);
    vectors++;
    if (found !== 1'b0) begin
      miscompares++; $display("FAIL genesis_miss_flag: got %b required 0", found);
    end
    test_range("wrap_hit", gen_mid, GEN_TAIL, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1);
    vectors++;
    if (found_nonce !== 32'hFFFFFFFE) begin
      miscompares++; $display("FAIL wrap_hit_nonce: got %h required fffffffe", found_nonce);
    end
    test_range("wrap_miss", gen_mid, GEN_TAIL, 32'h0, 32'hFFFFFFFE, 32'h00000001, 4);
    test_range("single", gen_mid, GEN_TAIL, 32'h0, 32'h12345678, 32'h12345678, 1);
  endtask

  task automatic test_random;
    logic [255:0] mid; logic [95:0] tl; logic [31:0] tgt, ns, ne;
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < 8; k++) mid[k*32 +: 32] = $urandom;
      for (int k = 0; k < 3; k++) tl[k*32 +: 32] = $urandom;
      tgt = $urandom >> $urandom_range(0, 6);
      if ($urandom_range(0, 2) == 0) ns = 32'hFFFFFFFF - 32'($urandom_range(0, 2));
      else ns = $urandom;
      ne = ns + 32'($urandom_range(0, 3));
      test_range("random", mid, tl, tgt, ns, ne, -1);
    end
  endtask

  task automatic test_abort;
    int base, s_base, w_base; bit ok;
    // abort while idle must not leak into the next search
    @(negedge clk); abort = 1'b1; @(negedge clk); abort = 1'b0;
    test_range("abort_idle", gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1E, 32'h7C2BAC20, 3);

    base = tried_q.size(); s_base = core_starts; w_base = words_served;
    launch(gen_mid, GEN_TAIL, 32'h0, 32'h00000000, 32'h000000FF);
    for (int k = 0; k < 2000 && words_served < w_base + 5; k++) @(negedge clk);
    abort = 1'b1; @(negedge clk); abort = 1'b0;
    wait_done("abort", ok);
    vectors++;
    if (words_served - w_base !== 16) begin
      miscompares++; $display("FAIL abort_words: got %0d required 16", words_served - w_base);
    end
    vectors++;
    if (core_starts - s_base !== 1) begin
      miscompares++; $display("FAIL abort_starts: got %0d required 1", core_starts - s_base);
    end
    vectors++;
    if (!ok || done_cyc - last_done_cyc > 2 || done_cyc < last_done_cyc) begin
      miscompares++; $display("FAIL abort_latency: got %0d cycles required <= 2", done_cyc - last_done_cyc);
    end
    vectors++;
    if (found !== 1'b0 || busy !== 1'b0) begin
      miscompares++; $display("FAIL abort_flags: got found=%b busy=%b required 0 0", found, busy);
    end
    vectors++;
    if (tried_q.size() - base !== 1) begin
      miscompares++; $display("FAIL abort_tries: got %0d required 1", tried_q.size() - base);
    end
  endtask

  task automatic test_reset_mid;
    int p_base, base; bit ok;
    p_base = p2_starts;
    launch(gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1A, 32'h7C2BAC20);
    for (int k = 0; k < 2000 && p2_starts == p_base; k++) @(negedge clk);
    vectors++;
    if (p2_starts == p_base) begin
      miscompares++; $display("FAIL rstmid_p2: got no pass-2 start required one");
    end
    repeat (4) @(negedge clk);
    rst = 1'b1; #1;
    vectors++;
    if ({busy, done, found, core_start, core_rdy} !== 5'b0) begin
      miscompares++; $display("FAIL rstmid_ctrl: got %b required 00000", {busy, done, found, core_start, core_rdy});
    end
    vectors++;
    if ({found_nonce, core_data} !== 64'h0 || {found_hash, core_state_in} !== 512'h0) begin
      miscompares++; $display("FAIL rstmid_data: got %h %h %h required 0", found_nonce, core_data, found_hash);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    base = tried_q.size();
    model_run(gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1A, 32'h7C2BAC20);
    launch(gen_mid, GEN_TAIL, 32'h0, 32'h7C2BAC1A, 32'h7C2BAC20);
    repeat (10) @(negedge clk);
    nonce_start = 32'h7C2BAC1D; target = 32'hFFFFFFFF; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_done("rstmid_run", ok);
    vectors++;
    if (tried_q.size() - base !== exp_q.size()) begin
      miscompares++; $display("FAIL rstmid_tries: got %0d required %0d", tried_q.size() - base, exp_q.size());
    end
    vectors++;
    if (found !== m_found || found_nonce !== m_nonce) begin
      miscompares++; $display("FAIL rstmid_result: got %b %h required %b %h", found, found_nonce, m_found, m_nonce);
    end
    vectors++;
    if (found_hash !== m_hash) begin
      miscompares++; $display("FAIL rstmid_hash: got %h required %h", found_hash, m_hash);
    end
  endtask

  task automatic test_protocol;
    vectors++;
    if (proto_err !== 0) begin
      miscompares++; $display("FAIL pulse_width: got %0d back-to-back rdy/done pulses required 0", proto_err);
    end
  endtask

  initial begin
    gen_mid = sha_compress(IV, GEN_BLK1);
    test_reset();
    test_genesis_hit();
    test_boundaries();
    test_random();
    test_abort();
    test_reset_mid();
    test_protocol();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/btc_nonce_sched.md
BTC_NONCE_SCHED -- requirements
Module: btc_nonce_sched

Interface
REQ-001 SHALL have parameter NONCE_W, default 32, meaning nonce counter width (fixed at 32; other values unsupported).
REQ-002 SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports start (input, 1, launch search pulse) and abort (input, 1, stop request).
REQ-005 SHALL have ports midstate (input, 256, SHA state after header block 1), tail (input, 96, header words 16..18 in SHA word order) and target (input, 32, hit threshold on H7).
REQ-006 SHALL have ports nonce_start and nonce_end (input, 32 each, inclusive search range).
REQ-007 SHALL have ports busy, done, found (output, 1 each), found_nonce (output, 32) and found_hash (output, 256).
REQ-008 SHALL have core-side ports: core_start (output, 1), core_state_in (output, 256), core_rq (input, 1), core_addr (input, 4), core_rdy (output, 1), core_data (output, 32), core_state_out (input, 256) and core_done (input, 1).

Function
REQ-009 SHALL use states IDLE, P1_GO, P1_WAIT, P2_GO, P2_WAIT, CHECK, FIN.
REQ-010 IDLE: on start, SHALL latch all inputs, set nonce to nonce_start, clear found, raise busy and go to P1_GO; start while busy SHALL be ignored.
REQ-011 P1_GO: SHALL pulse core_start for one cycle with core_state_in = midstate, then go to P1_WAIT.
REQ-012 Pass-1 words SHALL be: W0..W2 = tail[95:64], tail[63:32], tail[31:0]; W3 = byte-reversed nonce; W4 = 0x80000000; W5..W14 = 0; W15 = 0x00000280.
REQ-013 P1_WAIT: on core_done, SHALL register core_state_out as hash1 and go to P2_GO.
REQ-014 P2_GO: SHALL pulse core_start with core_state_in = SHA-256 IV, then go to P2_WAIT.
REQ-015 Pass-2 words SHALL be: W0..W7 = hash1 (H0 first); W8 = 0x80000000; W9..W14 = 0; W15 = 0x00000100.
REQ-016 Bus handshake: core_data SHALL be registered with the word for core_addr of the current pass.
REQ-017 Bus handshake: core_rdy SHALL be a registered single-cycle pulse, asserted the cycle after core_rq is sampled high while core_rdy is low, and never held two consecutive cycles.
REQ-018 P2_WAIT: on core_done, SHALL capture core_state_out into found_hash and go to CHECK.
REQ-019 CHECK hit (unsigned H7 = found_hash[31:0] <= target): SHALL set found, set found_nonce = nonce and go to FIN.
REQ-020 CHECK miss with nonce == nonce_end or abort pending: SHALL go to FIN with found = 0.
REQ-021 CHECK otherwise: SHALL set nonce = nonce + 1 modulo 2^32 (wraps 0xFFFFFFFF to 0) and go to P1_GO.
REQ-022 A range with nonce_end < nonce_start SHALL wrap through zero; nonce_start == nonce_end SHALL test exactly one nonce.
REQ-023 abort SHALL set a sticky pending flag; the controller SHALL keep servicing core_rq and finish the in-flight pass, never leaving the core mid-load; the flag SHALL be honoured at the next P1_GO/P2_GO/CHECK, which goes to FIN.
REQ-024 abort asserted in IDLE SHALL have no effect.
REQ-025 FIN: SHALL pulse done for one cycle, drop busy and return to IDLE; found, found_nonce and found_hash SHALL hold until the next accepted start.
REQ-026 Controller overhead per nonce SHALL be 3 cycles (P1_GO, P2_GO, CHECK) beyond the two core passes.

Reset
REQ-027 On rst, SHALL force: state = IDLE; busy, done, found, core_start and core_rdy = 0; found_nonce, core_data, core_state_in and found_hash = 0; abort flag cleared.
REQ-028 rst mid-search SHALL abandon the search immediately; the core SHALL share the same reset.

Structure
REQ-029 A shared package SHALL hold the SHA-256 IV, the padding constants 0x80000000, 0x00000280 and 0x00000100, and the state encodings.
REQ-030 One sub-module, btc_msg_mux, SHALL map (pass, addr, tail, nonce, hash1) to the 32-bit message word.

Verification
REQ-031 Genesis header (midstate and tail from the bench model), target = 0, range 0x7C2BAC1A..0x7C2BAC20 -> found = 1, found_nonce = 0x7C2BAC1D, 4 nonces tried, found_hash H7 = 0.
REQ-032 Same header, range 0x7C2BAC1E..0x7C2BAC20 -> done with found = 0 after exactly 3 nonces.
REQ-033 nonce_start = 0xFFFFFFFE, nonce_end = 0x00000001, target = 0xFFFFFFFF -> hit on the first nonce, found_nonce = 0xFFFFFFFE.
REQ-034 target = 0, same wrap range -> nonces tried in order FFFFFFFE, FFFFFFFF, 0, 1, then found = 0.
REQ-035 abort raised mid pass-1 -> all 16 core words still served, no second core_start, done within 2 cycles of core_done, found = 0.
REQ-036 rst asserted in P2_WAIT -> all outputs zero next cycle; a subsequent start runs normally; start while busy is ignored.
